// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared request type and source encodings for the regfile write arbiter
package regfile_write_arbiter_pkg;
  localparam int RF_ID_W = 5;
  typedef struct packed {
    logic [RF_ID_W-1:0] id;
    logic [31:0]        data;
  } regfile_wr_req_type;
  localparam logic WR_SRC_WB = 1'b0;
  localparam logic WR_SRC_LU = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter_wr_req_fifo.sv
// wr_req_fifo: in-order queue of pending long-latency register writes
module wr_req_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  regfile_wr_req_type         din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output regfile_wr_req_type         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  regfile_wr_req_type mem [DEPTH];
  // power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between writeback and a long-latency unit
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int REG_ID_W     = RF_ID_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wb_valid,
  input  logic [REG_ID_W-1:0]             wb_id,
  input  logic [31:0]                     wb_data,
  output logic                            wb_stall,
  input  logic                            lu_valid,
  output logic                            lu_ready,
  input  logic [REG_ID_W-1:0]             lu_id,
  input  logic [31:0]                     lu_data,
  output logic                            write_en,
  output logic [REG_ID_W-1:0]             write_id,
  output logic [31:0]                     write_data,
  output logic                            write_src,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  logic [SW-1:0] starve_cnt;
  logic full, empty, grant_lu, grant_wb;
  regfile_wr_req_type lu_req, head;
  assign lu_req   = '{id: lu_id, data: lu_data};
  assign grant_lu = !empty && (!wb_valid || starve_cnt == SW'(STARVE_LIMIT));
  assign grant_wb = wb_valid && !grant_lu;
  assign wb_stall = wb_valid && grant_lu;
  assign lu_ready = !full;
  wr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (lu_valid && lu_ready),
    .pop    (grant_lu),
    .din    (lu_req),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count),
    .head   (head)
  );
  // x0 requests are consumed but never raise write_en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_en   <= 1'b0;
      write_id   <= '0;
      write_data <= '0;
      write_src  <= WR_SRC_WB;
      starve_cnt <= '0;
    end else begin
      write_en <= (grant_wb && wb_id != '0) || (grant_lu && head.id != '0);
      if (grant_lu) begin
        write_id   <= head.id;
        write_data <= head.data;
        write_src  <= WR_SRC_LU;
      end else if (grant_wb) begin
        write_id   <= wb_id;
        write_data <= wb_data;
        write_src  <= WR_SRC_WB;
      end
      starve_cnt <= (grant_lu || empty) ? '0 :
                    (grant_wb && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
endmodule
